// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared definitions for the load/store unit.
//   - funct3 access encodings (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU)
//   - FSM state enum
//   - timeout counter width
//   - helpers for start legality and misalignment handling
package load_store_unit_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_e;

  // Encoding-level legality: unsigned sizes exist only for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    case (f3)
      LSU_B, LSU_H, LSU_W: return 1'b1;
      LSU_BU, LSU_HU:      return !we;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      LSU_H, LSU_HU: return off[0];
      LSU_W:         return |off;
      default:       return 1'b0;
    endcase
  endfunction

  // Force the offending low address bits to zero (align down to the access size).
  function automatic logic [1:0] align_down(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      LSU_H, LSU_HU: return {off[1], 1'b0};
      LSU_W:         return 2'b00;
      default:       return off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane selection and extension.
//   size_i  : funct3 access size/sign
//   off_i   : byte offset within the word (already aligned to the size)
//   rdata_i : memory read word      -> ld_o : addressed lane, sign/zero extended
//   wdata_i : store operand (low)   -> st_o : operand replicated across lanes
//                                      be_o : byte-lane enables for the store
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_o,
  output logic [31:0] st_o,
  output logic [3:0]  be_o
);

  logic [31:0] sh;

  always_comb begin
    // Bring the addressed lane down to bit 0.
    sh = rdata_i >> {off_i, 3'b000};
    case (size_i)
      LSU_B:   ld_o = {{24{sh[7]}}, sh[7:0]};
      LSU_H:   ld_o = {{16{sh[15]}}, sh[15:0]};
      LSU_BU:  ld_o = {24'h0, sh[7:0]};
      LSU_HU:  ld_o = {16'h0, sh[15:0]};
      default: ld_o = sh;
    endcase
  end

  always_comb begin
    case (size_i)
      LSU_B: begin
        st_o = {4{wdata_i[7:0]}};
        be_o = 4'b0001 << off_i;
      end
      LSU_H: begin
        st_o = {2{wdata_i[15:0]}};
        be_o = off_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_o = wdata_i;
        be_o = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-access load/store FSM (IDLE -> REQ -> RESP).
// Ports:
//   clk, reset (async, active-high)
//   start, we, funct3, AluResult, storeData : access request (sampled in IDLE)
//   loadData, done, err, busy               : result / status
//   memReq, memWe, memAddr, memByteEn, memWdata : registered memory request
//   memAck, memRdata                        : memory accept / read data
// Parameter TIMEOUT_CYCLES: REQ cycles without memAck before aborting.
// Build option: define LSU_MISALIGN_TRAP_EN to make misaligned H/HU/W accesses
// illegal; otherwise they are aligned down and proceed.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] AluResult,
  input  logic [31:0] storeData,
  output logic [31:0] loadData,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [3:0]  memByteEn,
  output logic [31:0] memWdata,
  input  logic        memAck,
  input  logic [31:0] memRdata
);

  lsu_state_e       state_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      load_q;
  logic             done_q, err_q;
  logic             req_q, mwe_q;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       be_q;

  logic        start_ok;
  logic [1:0]  start_off;
  logic [2:0]  al_size;
  logic [1:0]  al_off;
  logic [31:0] al_ld, al_st;
  logic [3:0]  al_be;

  assign start_off = align_down(funct3, AluResult[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign start_ok = f3_legal(funct3, we) && !misaligned(funct3, AluResult[1:0]);
`else
  assign start_ok = f3_legal(funct3, we);
`endif

  // One aligner serves both directions: in IDLE it builds the store lanes from
  // the incoming request, afterwards it extracts the load lane for the
  // registered access.
  always_comb begin
    al_size = funct3;
    al_off  = start_off;
    if (state_q != S_IDLE) begin
      al_size = f3_q;
      al_off  = off_q;
    end
  end

  lsu_align u_align (
    .size_i  (al_size),
    .off_i   (al_off),
    .rdata_i (memRdata),
    .wdata_i (storeData),
    .ld_o    (al_ld),
    .st_o    (al_st),
    .be_o    (al_be)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      load_q  <= 32'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      mwe_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (start) begin
            if (start_ok) begin
              state_q <= S_REQ;
              f3_q    <= funct3;
              off_q   <= start_off;
              we_q    <= we;
              cnt_q   <= '0;
              req_q   <= 1'b1;
              mwe_q   <= we;
              addr_q  <= {AluResult[31:2], 2'b00};
              be_q    <= we ? al_be : 4'b1111;
              wdata_q <= we ? al_st : 32'h0;
            end else begin
              // Illegal request: report straight away, no memory access.
              state_q <= S_RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (memAck) begin
            state_q <= S_RESP;
            req_q   <= 1'b0;
            mwe_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            if (!we_q) load_q <= al_ld;
          end else if (int'(cnt_q) + 1 >= TIMEOUT_CYCLES) begin
            state_q <= S_RESP;
            req_q   <= 1'b0;
            mwe_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            if (!we_q) load_q <= 32'h0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          cnt_q   <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign loadData  = load_q;
  assign memReq    = req_q;
  assign memWe     = mwe_q;
  assign memAddr   = addr_q;
  assign memByteEn = be_q;
  assign memWdata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit (default build,
// TIMEOUT_CYCLES=4). Expected completions are queued when an access starts
// and popped when done is seen.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, we;
  logic [2:0]  funct3;
  logic [31:0] AluResult, storeData;
  logic [31:0] loadData;
  logic        done, err, busy;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWdata;
  logic [3:0]  memByteEn;
  logic        memAck;
  logic [31:0] memRdata;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] ld;
    int          nreq;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .we        (we),
    .funct3    (funct3),
    .AluResult (AluResult),
    .storeData (storeData),
    .loadData  (loadData),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .memReq    (memReq),
    .memWe     (memWe),
    .memAddr   (memAddr),
    .memByteEn (memByteEn),
    .memWdata  (memWdata),
    .memAck    (memAck),
    .memRdata  (memRdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start and queue what its completion must look like.
  task automatic start_op(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic e_err, input logic [31:0] e_ld,
                          input int e_nreq, input logic [31:0] e_addr);
    exp_t e;
    e.tag = tag; e.err = e_err; e.ld = e_ld; e.nreq = e_nreq; e.addr = e_addr;
    sb.push_back(e);
    start = 1'b1; we = w; funct3 = f3; AluResult = a; storeData = sd;
    tick();
    start = 1'b0;
  endtask

  // Run until done (ack on loop step ack_at, -1 = never), then score it.
  task automatic finish_op(input int ack_at, input logic [31:0] rd);
    int   nreq;
    exp_t e;
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) break;
      if (memReq) begin
        nreq++;
        chk({sb[0].tag, " addr stable"}, memAddr, sb[0].addr);
      end
      memAck   = (i == ack_at);
      memRdata = rd;
      tick();
      memAck = 1'b0;
    end
    chk({sb[0].tag, " done"}, {31'h0, done}, 32'h1);
    e = sb.pop_front();
    chk({e.tag, " err"}, {31'h0, err}, {31'h0, e.err});
    chk({e.tag, " loadData"}, loadData, e.ld);
    chk({e.tag, " memReq cycles"}, nreq, e.nreq);
    chk({e.tag, " memReq after done"}, {31'h0, memReq}, 32'h0);
    tick();
    chk({e.tag, " idle"}, {30'h0, busy, done}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; we = 1'b0; funct3 = 3'b000;
    AluResult = 32'h0; storeData = 32'h0; memAck = 1'b0; memRdata = 32'h0;
    tick(); tick();
    chk("reset status", {28'h0, busy, done, err, memReq}, 32'h0);
    chk("reset loadData", loadData, 32'h0);
    chk("reset memAddr", memAddr, 32'h0);
    chk("reset memByteEn", {28'h0, memByteEn}, 32'h0);
    reset = 1'b0;
    tick();

    // memAck in IDLE is ignored
    memAck = 1'b1; tick(); memAck = 1'b0;
    chk("stray ack", {30'h0, busy, done}, 32'h0);

    // SW 0x100, ack on the third REQ cycle
    start_op("SW", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 3, 32'h100);
    chk("SW memReq/memWe/busy", {29'h0, memReq, memWe, busy}, 32'h7);
    chk("SW memByteEn", {28'h0, memByteEn}, 32'hF);
    chk("SW memWdata", memWdata, 32'hDEADBEEF);
    finish_op(2, 32'h0);

    // LB / LBU at 0x103
    start_op("LB", 1'b0, 3'b000, 32'h103, 32'h0, 1'b0, 32'hFFFFFF80, 1, 32'h100);
    chk("LB memWe", {31'h0, memWe}, 32'h0);
    chk("LB memByteEn", {28'h0, memByteEn}, 32'hF);
    finish_op(0, 32'h80112233);
    start_op("LBU", 1'b0, 3'b100, 32'h103, 32'h0, 1'b0, 32'h00000080, 1, 32'h100);
    finish_op(0, 32'h80112233);

    // SH 0x202; a start while busy must not disturb the access
    start_op("SH", 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 1'b0, 32'h00000080, 1, 32'h200);
    chk("SH memByteEn", {28'h0, memByteEn}, 32'hC);
    chk("SH memWdata", memWdata, 32'hABCDABCD);
    start = 1'b1; funct3 = 3'b011; AluResult = 32'h999; tick(); start = 1'b0;
    chk("start while busy", memAddr, 32'h200);
    finish_op(0, 32'h0);

    // SB 0x201
    start_op("SB", 1'b1, 3'b000, 32'h201, 32'h000000A5, 1'b0, 32'h00000080, 1, 32'h200);
    chk("SB memByteEn", {28'h0, memByteEn}, 32'h2);
    chk("SB memWdata", memWdata, 32'hA5A5A5A5);
    finish_op(0, 32'h0);

    // Misaligned accesses are aligned down in the default build
    start_op("LW mis", 1'b0, 3'b010, 32'h101, 32'h0, 1'b0, 32'h11223344, 1, 32'h100);
    chk("LW mis memAddr", memAddr, 32'h100);
    finish_op(0, 32'h11223344);
    start_op("LH mis", 1'b0, 3'b001, 32'h103, 32'h0, 1'b0, 32'hFFFFF00D, 1, 32'h100);
    finish_op(0, 32'hF00D1234);

    // Load timeout clears loadData
    start_op("LW tmo", 1'b0, 3'b010, 32'h300, 32'h0, 1'b1, 32'h0, 4, 32'h300);
    finish_op(-1, 32'h0);

    // LHU, then errors on stores must leave loadData alone
    start_op("LHU", 1'b0, 3'b101, 32'h002, 32'h0, 1'b0, 32'h00008000, 1, 32'h0);
    finish_op(0, 32'h80001234);
    start_op("SBU ill", 1'b1, 3'b100, 32'h010, 32'h0, 1'b1, 32'h00008000, 0, 32'h0);
    finish_op(-1, 32'h0);
    start_op("F3 ill", 1'b0, 3'b011, 32'h010, 32'h0, 1'b1, 32'h00008000, 0, 32'h0);
    finish_op(-1, 32'h0);
    start_op("SW tmo", 1'b1, 3'b010, 32'h500, 32'h12345678, 1'b1, 32'h00008000, 4, 32'h500);
    finish_op(-1, 32'h0);

    // Reset in REQ
    start = 1'b1; we = 1'b0; funct3 = 3'b010; AluResult = 32'h400; tick(); start = 1'b0;
    chk("pre-reset memReq", {31'h0, memReq}, 32'h1);
    reset = 1'b1;
    #1;
    chk("reset in REQ", {30'h0, memReq, busy}, 32'h0);
    chk("reset memAddr mid", memAddr, 32'h0);
    tick();
    reset = 1'b0;
    memAck = 1'b1; memRdata = 32'hCAFEF00D;
    tick();
    memAck = 1'b0;
    chk("late ack done", {30'h0, done, busy}, 32'h0);
    tick();
    chk("late ack loadData", loadData, 32'h0);
    chk("scoreboard drained", sb.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
